// File: rtl/vend_pkg.sv
// Shared types and constants for the two-channel vending dispense scheduler.
package vend_pkg;

  localparam int NUM_CH       = 2;
  localparam int CNT_W        = 4;
  localparam int DISP_CYC_DEF = 4;
  localparam int CHG_CYC_DEF  = 2;
  localparam int GAP_CYC_DEF  = 1;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    DISPENSE = 2'b01,
    RETURN   = 2'b10,
    GAP      = 2'b11
  } state_e;

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [NUM_CH-1:0] ch_vec_t;

  // Round robin: the channel that was not served last wins if it has work.
  function automatic logic pick_channel(input logic lp, input ch_vec_t pending);
    if (pending[~lp]) return ~lp;
    return lp;
  endfunction

  function automatic ch_vec_t onehot(input logic ch);
    return ch ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/vend_dispense_sched_if.sv
// Request/actuator bundle between the vending front-ends and the scheduler.
interface vend_dispense_sched_if;
  import vend_pkg::*;

  ch_vec_t prod_req;
  ch_vec_t chg_req;
  logic    motor;
  logic    coin_ret;
  ch_vec_t gnt;
  ch_vec_t done;
  logic    busy;
  ch_vec_t drop;

  modport master (
    output prod_req, chg_req,
    input  motor, coin_ret, gnt, done, busy, drop
  );

  modport slave (
    input  prod_req, chg_req,
    output motor, coin_ret, gnt, done, busy, drop
  );

endinterface

// File: rtl/vend_cycle_timer.sv
// Down-counter that times each scheduler phase; parks at zero rather than wrapping.
module vend_cycle_timer
  import vend_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  cnt_t load_val,
  output logic zero
);

  cnt_t count;

  // Load wins over counting; once at zero the count holds.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst)                count <= '0;
    else if (load)          count <= load_val;
    else if (count != '0)   count <= count - cnt_t'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/vend_dispense_sched.sv
// Shares one dispenser motor and one coin-return solenoid between two
// vending front-ends. Requests latch into pending flags; a round-robin FSM
// serves one channel at a time: dispense, then change, then a settling gap.
module vend_dispense_sched
  import vend_pkg::*;
#(
  parameter int DISP_CYC = DISP_CYC_DEF,
  parameter int CHG_CYC  = CHG_CYC_DEF,
  parameter int GAP_CYC  = GAP_CYC_DEF
) (
  input logic                  clk,
  input logic                  rst,
  vend_dispense_sched_if.slave bus
);

  localparam cnt_t DISP_LOAD = cnt_t'(DISP_CYC - 1);
  localparam cnt_t CHG_LOAD  = cnt_t'(CHG_CYC - 1);
  localparam cnt_t GAP_LOAD  = cnt_t'(GAP_CYC - 1);

  state_e  state, state_n;
  logic    cur, cur_n;          // channel owning the mechanism
  logic    lp;                  // last-served channel
  ch_vec_t req_p_q, req_c_q;    // requests sampled on the previous edge
  ch_vec_t pp, pc;              // pending product / change flags
  ch_vec_t pp_n, pc_n, drop_n;
  ch_vec_t clr_pp_vec, clr_pc_vec;
  ch_vec_t drop_q, done_q;

  logic tmr_load, tmr_zero;
  cnt_t tmr_val;
  logic clr_pp, clr_pc, done_set, lp_update;

  vend_cycle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Sample the front-end request lines once per edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_p_q <= '0;
      req_c_q <= '0;
    end else begin
      req_p_q <= bus.prod_req;
      req_c_q <= bus.chg_req;
    end
  end

  // FSM state, current grant and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cur   <= 1'b0;
      lp    <= 1'b1;
    end else begin
      state <= state_n;
      cur   <= cur_n;
      if (lp_update) lp <= cur;
    end
  end

  // Next-state logic; each phase entry reloads the timer with its length minus one.
  always_comb begin
    // NOTE: every signal gets a default first so no latch is inferred.
    state_n   = state;
    cur_n     = cur;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    clr_pp    = 1'b0;
    clr_pc    = 1'b0;
    done_set  = 1'b0;
    lp_update = 1'b0;
    case (state)
      IDLE: begin
        if (|(pp | pc)) begin
          cur_n    = pick_channel(lp, pp | pc);
          tmr_load = 1'b1;
          if (pp[cur_n]) begin
            state_n = DISPENSE;
            tmr_val = DISP_LOAD;
          end else begin
            state_n = RETURN;
            tmr_val = CHG_LOAD;
          end
        end
      end
      DISPENSE: begin
        if (tmr_zero) begin
          clr_pp   = 1'b1;
          tmr_load = 1'b1;
          // Change requested during the dispense rides on the same grant.
          if (pc[cur]) begin
            state_n = RETURN;
            tmr_val = CHG_LOAD;
          end else begin
            state_n  = GAP;
            tmr_val  = GAP_LOAD;
            done_set = 1'b1;
          end
        end
      end
      RETURN: begin
        if (tmr_zero) begin
          clr_pc   = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
          state_n  = GAP;
          done_set = 1'b1;
        end
      end
      GAP: begin
        if (tmr_zero) begin
          state_n   = IDLE;
          lp_update = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Pending-flag update: a new request beats a coincident clear; a repeat request is dropped.
  always_comb begin
    clr_pp_vec = clr_pp ? onehot(cur) : '0;
    clr_pc_vec = clr_pc ? onehot(cur) : '0;
    pp_n       = req_p_q | (pp & ~clr_pp_vec);
    pc_n       = req_c_q | (pc & ~clr_pc_vec);
    drop_n     = (req_p_q & pp & ~clr_pp_vec) | (req_c_q & pc & ~clr_pc_vec);
  end

  // Pending flags and the one-cycle drop/done pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pp     <= '0;
      pc     <= '0;
      drop_q <= '0;
      done_q <= '0;
    end else begin
      pp     <= pp_n;
      pc     <= pc_n;
      drop_q <= drop_n;
      done_q <= done_set ? onehot(cur) : '0;
    end
  end

  assign bus.motor    = (state == DISPENSE);
  assign bus.coin_ret = (state == RETURN);
  assign bus.busy     = (state != IDLE);
  assign bus.gnt      = (state != IDLE) ? onehot(cur) : '0;
  assign bus.done     = done_q;
  assign bus.drop     = drop_q;

endmodule

// File: tb/tb_vend_dispense_sched.sv
// Directed bench for vend_dispense_sched. Inputs change and outputs are
// compared on the falling edge. Output vector bits, MSB first:
// motor, coin_ret, busy, gnt[1:0], done[1:0], drop[1:0].
module tb_vend_dispense_sched;
  import vend_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  vend_dispense_sched_if bus ();

  vend_dispense_sched #(
    .DISP_CYC (4),
    .CHG_CYC  (2),
    .GAP_CYC  (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] outs();
    return {bus.motor, bus.coin_ret, bus.busy, bus.gnt, bus.done, bus.drop};
  endfunction

  function automatic logic inr(input int i, input int lo, input int hi);
    return (i >= lo) && (i <= hi);
  endfunction

  // Mechanism exclusivity holds on every cycle.
  always @(negedge clk) begin
    n_checks++;
    if ((bus.motor & bus.coin_ret) === 1'b1 || $onehot0(bus.gnt) !== 1'b1)
      $display("FAIL exclusive: motor=%b coin_ret=%b gnt=%b", bus.motor, bus.coin_ret, bus.gnt);
    else
      n_pass++;
  end

  task automatic apply_reset();
    rst          = 1'b1;
    bus.prod_req = 2'b00;
    bus.chg_req  = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.prod_req = 2'b11;
    bus.chg_req  = 2'b11;
    @(negedge clk);
    n_checks++;
    if (outs() !== 9'b0) $display("FAIL reset_held: got %b want %b", outs(), 9'b0);
    else n_pass++;
    bus.prod_req = 2'b00;
    bus.chg_req  = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (outs() !== 9'b0) $display("FAIL reset_release cyc %0d: got %b want %b", i, outs(), 9'b0);
      else n_pass++;
    end
  endtask

  task automatic test_single();
    logic [8:0] want;
    apply_reset();
    bus.prod_req = 2'b01;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      want = {inr(i, 3, 6), 1'b0, inr(i, 3, 7), inr(i, 3, 7) ? 2'b01 : 2'b00,
              (i == 7) ? 2'b01 : 2'b00, 2'b00};
      n_checks++;
      if (outs() !== want) $display("FAIL single cyc %0d: got %b want %b", i, outs(), want);
      else n_pass++;
      if (i == 1) bus.prod_req = 2'b00;
    end
  endtask

  task automatic test_both_channels();
    logic [8:0] want;
    apply_reset();
    bus.prod_req = 2'b11;
    bus.chg_req  = 2'b11;
    for (int i = 1; i <= 19; i++) begin
      @(negedge clk);
      want = {inr(i, 3, 6) || inr(i, 11, 14),
              inr(i, 7, 8) || inr(i, 15, 16),
              inr(i, 3, 9) || inr(i, 11, 17),
              inr(i, 3, 9) ? 2'b01 : (inr(i, 11, 17) ? 2'b10 : 2'b00),
              (i == 9) ? 2'b01 : ((i == 17) ? 2'b10 : 2'b00),
              2'b00};
      n_checks++;
      if (outs() !== want) $display("FAIL both cyc %0d: got %b want %b", i, outs(), want);
      else n_pass++;
      if (i == 1) begin
        bus.prod_req = 2'b00;
        bus.chg_req  = 2'b00;
      end
    end
  endtask

  task automatic test_change_only();
    logic [8:0] want;
    apply_reset();
    bus.chg_req = 2'b10;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      want = {1'b0, inr(i, 3, 4), inr(i, 3, 5), inr(i, 3, 5) ? 2'b10 : 2'b00,
              (i == 5) ? 2'b10 : 2'b00, 2'b00};
      n_checks++;
      if (outs() !== want) $display("FAIL chg_only cyc %0d: got %b want %b", i, outs(), want);
      else n_pass++;
      if (i == 1) bus.chg_req = 2'b00;
    end
  endtask

  task automatic test_drop();
    logic [8:0] want;
    apply_reset();
    bus.chg_req = 2'b10;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      want = {inr(i, 7, 10), inr(i, 3, 4), inr(i, 3, 5) || inr(i, 7, 11),
              inr(i, 3, 5) ? 2'b10 : (inr(i, 7, 11) ? 2'b01 : 2'b00),
              (i == 5) ? 2'b10 : ((i == 11) ? 2'b01 : 2'b00),
              (i == 6) ? 2'b01 : 2'b00};
      n_checks++;
      if (outs() !== want) $display("FAIL drop cyc %0d: got %b want %b", i, outs(), want);
      else n_pass++;
      case (i)
        1:       bus.chg_req  = 2'b00;
        2, 4:    bus.prod_req = 2'b01;
        3, 5:    bus.prod_req = 2'b00;
        default: ;
      endcase
    end
  endtask

  task automatic test_chg_during_dispense();
    logic [8:0] want;
    apply_reset();
    bus.prod_req = 2'b01;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      want = {inr(i, 3, 6), inr(i, 7, 8), inr(i, 3, 9), inr(i, 3, 9) ? 2'b01 : 2'b00,
              (i == 9) ? 2'b01 : 2'b00, 2'b00};
      n_checks++;
      if (outs() !== want) $display("FAIL chg_in_disp cyc %0d: got %b want %b", i, outs(), want);
      else n_pass++;
      case (i)
        1:       bus.prod_req = 2'b00;
        4:       bus.chg_req  = 2'b01;
        5:       bus.chg_req  = 2'b00;
        default: ;
      endcase
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] want;
    apply_reset();
    bus.prod_req = 2'b01;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      want = {inr(i, 3, 6) || inr(i, 9, 12), 1'b0, inr(i, 3, 7) || inr(i, 9, 13),
              (inr(i, 3, 7) || inr(i, 9, 13)) ? 2'b01 : 2'b00,
              (i == 7 || i == 13) ? 2'b01 : 2'b00, 2'b00};
      n_checks++;
      if (outs() !== want) $display("FAIL back_to_back cyc %0d: got %b want %b", i, outs(), want);
      else n_pass++;
      case (i)
        1, 6:    bus.prod_req = 2'b00;
        5:       bus.prod_req = 2'b01;
        default: ;
      endcase
    end
  endtask

  task automatic test_reset_mid_dispense();
    logic [8:0] want;
    apply_reset();
    bus.prod_req = 2'b01;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      want = {inr(i, 3, 4), 1'b0, inr(i, 3, 4), inr(i, 3, 4) ? 2'b01 : 2'b00, 2'b00, 2'b00};
      n_checks++;
      if (outs() !== want) $display("FAIL rst_mid_pre cyc %0d: got %b want %b", i, outs(), want);
      else n_pass++;
      case (i)
        1:       bus.prod_req = 2'b00;
        2:       bus.chg_req  = 2'b10;
        3:       bus.chg_req  = 2'b00;
        default: ;
      endcase
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (outs() !== 9'b0) $display("FAIL rst_mid_async: got %b want %b", outs(), 9'b0);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      n_checks++;
      if (outs() !== 9'b0) $display("FAIL rst_mid_post cyc %0d: got %b want %b", i, outs(), 9'b0);
      else n_pass++;
    end
  endtask

  initial begin
    bus.prod_req = 2'b00;
    bus.chg_req  = 2'b00;
    test_reset();
    test_single();
    test_both_channels();
    test_change_only();
    test_drop();
    test_chg_during_dispense();
    test_back_to_back();
    test_reset_mid_dispense();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
